// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, block sizes and message-schedule sigma functions.
package sha256_pkg;

   localparam int MSG_WORDS   = 16;
   localparam int SCHED_WORDS = 64;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND,
      DONE
   } state_t;

   function automatic word_t sigma0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic word_t sigma1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/msg_window.sv
// 16-deep sliding window of schedule words; win[0] holds the newest word W[t-1].
module msg_window
   import sha256_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        shift,
   input  logic [31:0] din,
   output logic [31:0] tap2,
   output logic [31:0] tap7,
   output logic [31:0] tap15,
   output logic [31:0] tap16
);

   word_t win [MSG_WORDS];

   // NOTE: the window is plain flops, so it is reset like any other state; a
   // stale word must never leak into a run that restarts after an abort.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MSG_WORDS; i++) win[i] <= '0;
      end else if (shift) begin
         win[0] <= din;
         for (int i = 1; i < MSG_WORDS; i++) win[i] <= win[i-1];
      end
   end

   assign tap2  = win[1];
   assign tap7  = win[6];
   assign tap15 = win[14];
   assign tap16 = win[15];

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: reads one 16-word block, emits W[0..63] one per cycle,
// then holds done until enable drops.
module msg_schedule
   import sha256_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] msg_data,
   output logic        msg_rd,
   output logic [3:0]  msg_addr,
   output logic        w_valid,
   output logic [5:0]  w_index,
   output logic [31:0] w_data,
   output logic        done
);

   state_t     state;
   logic [6:0] count;   // index of the next word to be emitted
   logic       rd_q;    // msg_data carries a requested word this cycle
   logic       shift;
   word_t      w_new;
   word_t      src;
   word_t      tap2, tap7, tap15, tap16;

   msg_window u_window (
      .clock (clock),
      .reset (reset),
      .shift (shift),
      .din   (src),
      .tap2  (tap2),
      .tap7  (tap7),
      .tap15 (tap15),
      .tap16 (tap16)
   );

   // NOTE: every combinational output gets a value on every path, so no latch.
   always_comb begin
      w_new = sigma1(tap2) + tap7 + sigma0(tap15) + tap16;
      src   = rd_q ? msg_data : w_new;
      shift = rd_q || (state == EXPAND && count != 7'(SCHED_WORDS));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge value of every other register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         rd_q     <= 1'b0;
         msg_rd   <= 1'b0;
         msg_addr <= '0;
         w_valid  <= 1'b0;
         w_index  <= '0;
         w_data   <= '0;
         done     <= 1'b0;
      end else begin
         rd_q    <= msg_rd;
         w_valid <= shift;
         if (shift) begin
            w_data  <= src;
            w_index <= count[5:0];
            count   <= count + 7'd1;
         end

         case (state)
            IDLE: begin
               if (enable) begin
                  state    <= LOAD;
                  count    <= '0;
                  msg_rd   <= 1'b1;
                  msg_addr <= '0;
               end
            end
            LOAD: begin
               // Last read issued; W[15] itself is captured during the first EXPAND cycle.
               if (msg_addr == 4'(MSG_WORDS - 1)) begin
                  state    <= EXPAND;
                  msg_rd   <= 1'b0;
                  msg_addr <= '0;
               end else begin
                  msg_addr <= msg_addr + 4'd1;
               end
            end
            EXPAND: begin
               if (count == 7'(SCHED_WORDS)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (!enable) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: abc block, zero block, back-to-back, reset abort, enable drop.
module tb_msg_schedule;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] msg_data;
   logic        msg_rd;
   logic [3:0]  msg_addr;
   logic        w_valid;
   logic [5:0]  w_index;
   logic [31:0] w_data;
   logic        done;

   logic [31:0] mem   [16];
   logic [31:0] exp_w [64];
   logic [31:0] got_w [64];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   msg_schedule dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .msg_data (msg_data),
      .msg_rd   (msg_rd),
      .msg_addr (msg_addr),
      .w_valid  (w_valid),
      .w_index  (w_index),
      .w_data   (w_data),
      .done     (done)
   );

   // Synchronous-read message memory; junk when not read.
   always @(posedge clock) msg_data <= msg_rd ? mem[msg_addr] : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void build_ref();
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) exp_w[t] = mem[t];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
         s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
         exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
   endfunction

   // Called at a negedge; cycle c below is cycle N+c of the run.
   task automatic run_block(input string tag, input int drop_at, input int abort_at);
      int   rd_count, rd_err, v_count, v_first, v_last, idx_err, data_err;
      logic d65, d66, d67;
      build_ref();
      rd_count = 0; rd_err = 0; v_count = 0; v_first = -1; v_last = -1;
      idx_err = 0; data_err = 0; d65 = 1'bx; d66 = 1'bx; d67 = 1'bx;
      enable = 1'b1;
      for (int c = 0; c < 70; c++) begin
         @(negedge clock);
         if (abort_at >= 0 && c == abort_at + 2) begin
            check({tag, ".abort_idx"}, 32'(w_index), 32'(abort_at));
            reset = 1'b0;
            #1;
            check({tag, ".rst_wdata"}, w_data, 32'h0);
            check({tag, ".rst_ctl"}, 32'({msg_rd, msg_addr, w_valid, w_index, done}), 32'h0);
            return;
         end
         if (drop_at >= 0 && c == drop_at + 2) enable = 1'b0;
         if (msg_rd !== (c < 16)) rd_err++;
         if (msg_rd === 1'b1) begin
            if (msg_addr !== rd_count[3:0]) rd_err++;
            rd_count++;
         end else if (msg_addr !== 4'd0) begin
            rd_err++;
         end
         if (w_valid === 1'b1) begin
            if (v_first < 0) v_first = c;
            v_last = c;
            v_count++;
            if (int'(w_index) != c - 2) idx_err++;
            if (w_data !== exp_w[w_index]) data_err++;
            got_w[w_index] = w_data;
         end
         if (c == 65) d65 = done;
         if (c == 66) d66 = done;
         if (c == 67) d67 = done;
      end
      check({tag, ".rd_count"}, 32'(rd_count), 32'd16);
      check({tag, ".rd_order"}, 32'(rd_err), 32'd0);
      check({tag, ".valid_count"}, 32'(v_count), 32'd64);
      check({tag, ".valid_first"}, 32'(v_first), 32'd2);
      check({tag, ".valid_last"}, 32'(v_last), 32'd65);
      check({tag, ".index_seq"}, 32'(idx_err), 32'd0);
      check({tag, ".data"}, 32'(data_err), 32'd0);
      check({tag, ".done_n65"}, 32'(d65), 32'd0);
      check({tag, ".done_n66"}, 32'(d66), 32'd1);
      check({tag, ".done_n67"}, 32'(d67), (drop_at >= 0) ? 32'd0 : 32'd1);
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(negedge clock);
      check("reset.wdata", w_data, 32'h0);
      check("reset.ctl", 32'({msg_rd, msg_addr, w_valid, w_index, done}), 32'h0);
      reset = 1'b1;
      @(negedge clock);
      check("idle.ctl", 32'({msg_rd, w_valid, done}), 32'h0);

      // "abc" padded block against published schedule words
      mem[0]  = 32'h6162_6380;
      mem[15] = 32'h0000_0018;
      run_block("abc", -1, -1);
      check("abc.W0",  got_w[0],  32'h6162_6380);
      check("abc.W15", got_w[15], 32'h0000_0018);
      check("abc.W16", got_w[16], 32'h6162_6380);
      check("abc.W17", got_w[17], 32'h000F_0000);
      check("abc.W63", got_w[63], 32'h12B1_EDEB);

      // Back-to-back: enable low for one cycle in DONE, new contents
      enable = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h9E37_79B9;
      @(negedge clock);
      run_block("b2b", -1, -1);

      enable = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      @(negedge clock);
      run_block("zero", -1, -1);
      check("zero.W40", got_w[40], 32'h0);

      // Asynchronous reset mid-EXPAND, then a fresh run
      enable = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 + 32'(i * 7919);
      @(negedge clock);
      run_block("abort", -1, 30);
      repeat (2) @(negedge clock);
      check("abort.held", 32'({msg_rd, w_valid, done}), 32'h0);
      reset = 1'b1;
      run_block("restart", -1, -1);

      // enable dropped after W[5]; block still completes, then returns to IDLE
      enable = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF - 32'(i * 3);
      @(negedge clock);
      run_block("drop", 5, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
